// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / divide unit with HI/LO result registers.
// Fixed 34-edge schedule: latch at E0, 32 iterations, sign fix-up and writeback at E33.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t      state;
  logic [4:0]  count;
  logic        is_div_q;
  logic        neg_res_q;
  logic        neg_rem_q;
  logic        b_zero_q;
  logic [31:0] a_q;
  logic [31:0] m_q;       // multiplicand / divisor magnitude
  logic [31:0] acc_hi;    // partial product upper word / partial remainder
  logic [31:0] acc_lo;    // multiplier bits / quotient bits

  // Operand decode at the accept edge; op[0]=0 selects the signed variants.
  logic        is_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  always_comb begin
    is_signed = ~op[0];
    a_mag     = (is_signed && a[31]) ? -a : a;
    b_mag     = (is_signed && b[31]) ? -b : b;
  end

  // One iteration of shift-add multiply and restoring shift-subtract divide.
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_q} : 33'd0);
    div_shift = {acc_hi, acc_lo[31]};
    div_ge    = div_shift >= {1'b0, m_q};
    // When div_ge holds the true difference is below the divisor, so 32 bits suffice.
    div_diff  = div_shift[31:0] - m_q;
  end

  // Sign correction applied at the FINISH edge.
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    prod_fix = neg_res_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_fix  = neg_res_q ? -acc_lo : acc_lo;
    rem_fix  = neg_rem_q ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all updates see pre-edge values, whatever the statement order.
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      count     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      a_q       <= '0;
      m_q       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            state     <= CALC;
            busy      <= 1'b1;
            count     <= 5'd31;
            is_div_q  <= op[1];
            neg_res_q <= is_signed && (a[31] ^ b[31]);
            neg_rem_q <= is_signed && a[31];
            b_zero_q  <= (b == 32'd0);
            a_q       <= a;
            m_q       <= b_mag;
            acc_hi    <= '0;
            acc_lo    <= a_mag;
          end
        end
        CALC: begin
          if (is_div_q) begin
            acc_hi <= div_ge ? div_diff : div_shift[31:0];
            acc_lo <= {acc_lo[30:0], div_ge};
          end else begin
            acc_hi <= mul_sum[32:1];
            acc_lo <= {mul_sum[0], acc_lo[31:1]};
          end
          if (count == 5'd0) state <= FINISH;
          else               count <= count - 5'd1;
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (!is_div_q) begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end else if (b_zero_q) begin
            hi <= a_q;
            lo <= 32'hFFFF_FFFF;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
